// File: rtl/regfile_wb_scheduler_if.sv
// Handshake/bus bundle for regfile_wb_scheduler.
// master drives issue/writeback requests; slave is the scheduler.
interface regfile_wb_scheduler_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   issue_rs1;
  logic [AW-1:0]   issue_rs2;
  logic            issue_stall;
  logic            flush;
  logic            wb0_valid;
  logic [AW-1:0]   wb0_rd;
  logic [XLEN-1:0] wb0_data;
  logic            wb0_ready;
  logic            wb1_valid;
  logic [AW-1:0]   wb1_rd;
  logic [XLEN-1:0] wb1_data;
  logic            wb1_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_write_data;
  logic [AW:0]     busy_count;

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
    output flush,
    output wb0_valid, wb0_rd, wb0_data,
    output wb1_valid, wb1_rd, wb1_data,
    input  issue_stall, wb0_ready, wb1_ready,
    input  rf_we, rf_rd, rf_write_data, busy_count
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
    input  flush,
    input  wb0_valid, wb0_rd, wb0_data,
    input  wb1_valid, wb1_rd, wb1_data,
    output issue_stall, wb0_ready, wb1_ready,
    output rf_we, rf_rd, rf_write_data, busy_count
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter (ALU/LSU round-robin) with
// per-register busy scoreboard driving issue stall.
module regfile_wb_scheduler #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_scheduler_if.slave bus
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [AW:0]         r_cnt;
  logic [AW:0]         w_cnt_nxt;
  logic                r_ptr;
  logic                r_we;
  logic [AW-1:0]       r_rd;
  logic [XLEN-1:0]     r_data;

  logic w_stall;
  logic w_accept;
  logic w_g0;
  logic w_g1;

  assign w_stall = bus.issue_valid &
                   (r_busy[bus.issue_rs1] |
                    r_busy[bus.issue_rs2] |
                    r_busy[bus.issue_rd]);

  assign w_accept = bus.issue_valid & ~w_stall & ~bus.flush;

  assign w_g0 = ~bus.flush & bus.wb0_valid &
                (~bus.wb1_valid | ~r_ptr);
  assign w_g1 = ~bus.flush & bus.wb1_valid &
                (~bus.wb0_valid | r_ptr);

  // Clear from the write port is applied first so a same-edge set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.flush) begin
      w_busy_nxt = '0;
    end else begin
      if (r_we)
        w_busy_nxt[r_rd] = 1'b0;
      if (w_accept)
        w_busy_nxt[bus.issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= 1'b0;
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_g0) begin
        r_ptr  <= 1'b1;
        r_we   <= (bus.wb0_rd != '0);
        r_rd   <= bus.wb0_rd;
        r_data <= bus.wb0_data;
      end else if (w_g1) begin
        r_ptr  <= 1'b0;
        r_we   <= (bus.wb1_rd != '0);
        r_rd   <= bus.wb1_rd;
        r_data <= bus.wb1_data;
      end
    end
  end

  assign bus.issue_stall   = w_stall;
  assign bus.wb0_ready     = w_g0;
  assign bus.wb1_ready     = w_g1;
  assign bus.rf_we         = r_we;
  assign bus.rf_rd         = r_rd;
  assign bus.rf_write_data = r_data;
  assign bus.busy_count    = r_cnt;

endmodule
